// File: rtl/axi_lite_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_arbiter_2m
// Description : Two-master to one-slave AXI-Lite arbiter. Serves exactly one
//               transaction (a single write or a single read) at a time, end
//               to end, with round-robin arbitration between the masters and
//               write-before-read priority within a master.
// Ports       : aclk, areset      - clock, asynchronous active-high reset
//               m0_* / m1_*       - AXI-Lite slave ports facing master 0 / 1
//               s_*               - AXI-Lite master port toward the shared slave
//               gnt               - one-hot current owner, 2'b00 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter_2m #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    // master 0
    input  logic [ADDR_W-1:0]     m0_awaddr,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [1:0]            m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    // master 1
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    // shared slave
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    // owner
    output logic [1:0]            gnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       owner, owner_nxt;     // 0 = master 0, 1 = master 1
    logic       rr, rr_nxt;           // preferred master on a tie
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;
    logic [1:0] gnt_nxt;

    // Requests and arbitration result, only consulted in IDLE
    logic req0, req1, win, win_is_write;

    // Signals of whichever master currently owns the slave
    logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

    // Readys/valids toward the owner before per-master steering
    logic fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;

    assign req0         = m0_awvalid | m0_arvalid;
    assign req1         = m1_awvalid | m1_arvalid;
    assign win          = (req0 && req1) ? rr : req1;
    assign win_is_write = win ? m1_awvalid : m0_awvalid;

    assign sel_awvalid  = owner ? m1_awvalid : m0_awvalid;
    assign sel_wvalid   = owner ? m1_wvalid  : m0_wvalid;
    assign sel_bready   = owner ? m1_bready  : m0_bready;
    assign sel_arvalid  = owner ? m1_arvalid : m0_arvalid;
    assign sel_rready   = owner ? m1_rready  : m0_rready;

    // Payload follows the owner unconditionally; only the valids are gated.
    assign s_awaddr     = owner ? m1_awaddr : m0_awaddr;
    assign s_wdata      = owner ? m1_wdata  : m0_wdata;
    assign s_wstrb      = owner ? m1_wstrb  : m0_wstrb;
    assign s_araddr     = owner ? m1_araddr : m0_araddr;

    assign m0_bresp     = s_bresp;
    assign m1_bresp     = s_bresp;
    assign m0_rdata     = s_rdata;
    assign m1_rdata     = s_rdata;
    assign m0_rresp     = s_rresp;
    assign m1_rresp     = s_rresp;

    // fwd_* are zero outside an active transaction, so steering by owner alone
    // keeps both masters quiet while idle.
    assign m0_awready   = fwd_awready & ~owner;
    assign m1_awready   = fwd_awready &  owner;
    assign m0_wready    = fwd_wready  & ~owner;
    assign m1_wready    = fwd_wready  &  owner;
    assign m0_bvalid    = fwd_bvalid  & ~owner;
    assign m1_bvalid    = fwd_bvalid  &  owner;
    assign m0_arready   = fwd_arready & ~owner;
    assign m1_arready   = fwd_arready &  owner;
    assign m0_rvalid    = fwd_rvalid  & ~owner;
    assign m1_rvalid    = fwd_rvalid  &  owner;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr      <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            gnt     <= 2'b00;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr      <= rr_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            gnt     <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        fwd_awready = 1'b0;
        fwd_wready  = 1'b0;
        fwd_bvalid  = 1'b0;
        fwd_arready = 1'b0;
        fwd_rvalid  = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nxt = win;
                    state_nxt = win_is_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // AW and W complete independently; each is forwarded only
                // until its own handshake has been seen.
                s_awvalid   = sel_awvalid & ~aw_done;
                s_wvalid    = sel_wvalid  & ~w_done;
                fwd_awready = s_awready   & ~aw_done;
                fwd_wready  = s_wready    & ~w_done;
                aw_done_nxt = aw_done | (s_awvalid & s_awready);
                w_done_nxt  = w_done  | (s_wvalid  & s_wready);
                if (aw_done_nxt && w_done_nxt) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                s_bready   = sel_bready;
                fwd_bvalid = s_bvalid;
                if (s_bvalid && sel_bready) begin
                    state_nxt   = IDLE;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    rr_nxt      = ~owner;
                end
            end
            RADDR: begin
                s_arvalid   = sel_arvalid;
                fwd_arready = s_arready;
                if (sel_arvalid && s_arready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                s_rready   = sel_rready;
                fwd_rvalid = s_rvalid;
                if (s_rvalid && sel_rready) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~owner;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        gnt_nxt = (state_nxt == IDLE) ? 2'b00 : {owner_nxt, ~owner_nxt};
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_arbiter_2m
// Description : Directed self-checking bench for axi_lite_arbiter_2m. The
//               bench plays both masters and the shared slave directly, one
//               cycle at a time, with hand-derived expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arbiter_2m;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic aclk, areset;
    logic [ADDR_W-1:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr, s_awaddr, s_araddr;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic [DATA_W/8-1:0] m0_wstrb, m1_wstrb, s_wstrb;
    logic [1:0] m0_bresp, m1_bresp, m0_rresp, m1_rresp, s_bresp, s_rresp, gnt;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;

    int n_compared   = 0;
    int n_mismatched = 0;

    axi_lite_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .areset(areset),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .gnt(gnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset = 1'b1;
        {m0_awaddr, m0_awvalid, m0_wdata, m0_wstrb, m0_wvalid, m0_bready, m0_araddr, m0_arvalid, m0_rready} = '0;
        {m1_awaddr, m1_awvalid, m1_wdata, m1_wstrb, m1_wvalid, m1_bready, m1_araddr, m1_arvalid, m1_rready} = '0;
        {s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid} = '0;
        tick();
        tick();

        // ---- reset state: requests present but ignored ----
        m0_awvalid = 1'b1; m1_arvalid = 1'b1; s_awready = 1'b1; s_arready = 1'b1;
        #1;
        check_eq("rst_gnt",       gnt,        2'b00);
        check_eq("rst_s_awvalid", s_awvalid,  1'b0);
        check_eq("rst_s_arvalid", s_arvalid,  1'b0);
        check_eq("rst_m0_awready", m0_awready, 1'b0);
        check_eq("rst_m1_arready", m1_arready, 1'b0);
        tick();
        m0_awvalid = 1'b0; m1_arvalid = 1'b0; s_awready = 1'b0; s_arready = 1'b0;
        areset = 1'b0;

        // ---- single m0 write ----
        m0_awaddr = 4'h4; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
        m0_awvalid = 1'b1; m0_wvalid = 1'b1; m0_bready = 1'b1;
        #1;
        check_eq("w1_idle_gnt",     gnt,       2'b00);
        check_eq("w1_idle_awvalid", s_awvalid, 1'b0);
        tick();
        check_eq("w1_gnt",      gnt,       2'b01);
        check_eq("w1_s_awvalid", s_awvalid, 1'b1);
        check_eq("w1_s_awaddr", s_awaddr,  4'h4);
        check_eq("w1_s_wvalid", s_wvalid,  1'b1);
        check_eq("w1_s_wdata",  s_wdata,   32'hDEADBEEF);
        check_eq("w1_s_wstrb",  s_wstrb,   4'hF);
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        check_eq("w1_m0_awready", m0_awready, 1'b1);
        check_eq("w1_m0_wready",  m0_wready,  1'b1);
        check_eq("w1_m1_awready", m1_awready, 1'b0);
        tick();
        m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        #1;
        check_eq("w1_m0_bvalid", m0_bvalid, 1'b1);
        check_eq("w1_m0_bresp",  m0_bresp,  2'b00);
        check_eq("w1_s_bready",  s_bready,  1'b1);
        check_eq("w1_m1_bvalid", m1_bvalid, 1'b0);
        check_eq("w1_wresp_awvalid", s_awvalid, 1'b0);
        tick();
        s_bvalid = 1'b0; m0_bready = 1'b0;
        check_eq("w1_end_gnt", gnt, 2'b00);

        // ---- both masters read: m1 preferred now; m0 held off then served ----
        m0_araddr = 4'h8; m1_araddr = 4'hC; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        tick();
        check_eq("rr_gnt_m1",   gnt,       2'b10);
        check_eq("rr_s_araddr", s_araddr,  4'hC);
        s_arready = 1'b1;
        #1;
        check_eq("rr_m1_arready", m1_arready, 1'b1);
        check_eq("rr_m0_arready", m0_arready, 1'b0);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h12345678; s_rresp = 2'b10; m1_rready = 1'b1;
        #1;
        check_eq("rr_m1_rvalid", m1_rvalid, 1'b1);
        check_eq("rr_m1_rdata",  m1_rdata,  32'h12345678);
        check_eq("rr_m1_rresp",  m1_rresp,  2'b10);
        check_eq("rr_m0_rvalid", m0_rvalid, 1'b0);
        check_eq("rr_s_rready",  s_rready,  1'b1);
        check_eq("rr_rdata_arvalid", s_arvalid, 1'b0);
        tick();
        s_rvalid = 1'b0; m1_rready = 1'b0;
        check_eq("rr_turn_gnt", gnt, 2'b00);
        tick();
        check_eq("rr_gnt_m0",   gnt,      2'b01);
        check_eq("rr_s_araddr0", s_araddr, 4'h8);
        s_arready = 1'b1;
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h0000BEEF; s_rresp = 2'b00; m0_rready = 1'b1;
        #1;
        check_eq("rr_m0_rdata", m0_rdata, 32'h0000BEEF);
        tick();
        s_rvalid = 1'b0; m0_rready = 1'b0;

        // ---- reset, then simultaneous writes: m0 first, then m1 ----
        areset = 1'b1;
        tick();
        areset = 1'b0;
        m0_awaddr = 4'h0; m0_wdata = 32'h11111111; m0_wstrb = 4'h3;
        m1_awaddr = 4'hC; m1_wdata = 32'h22222222; m1_wstrb = 4'hC;
        m0_awvalid = 1'b1; m0_wvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        m0_bready = 1'b1; m1_bready = 1'b1;
        tick();
        check_eq("dual_gnt0",    gnt,      2'b01);
        check_eq("dual_s_wdata0", s_wdata, 32'h11111111);
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        check_eq("dual_m1_awready", m1_awready, 1'b0);
        tick();
        m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1;
        #1;
        check_eq("dual_m1_bvalid", m1_bvalid, 1'b0);
        tick();
        s_bvalid = 1'b0;
        check_eq("dual_gnt_idle", gnt, 2'b00);
        tick();
        check_eq("dual_gnt1",     gnt,      2'b10);
        check_eq("dual_s_awaddr1", s_awaddr, 4'hC);
        check_eq("dual_s_wstrb1",  s_wstrb,  4'hC);
        // Slave takes W two cycles before AW; m1 keeps wvalid high meanwhile.
        s_wready = 1'b1;
        #1;
        check_eq("wfirst_m1_wready",  m1_wready,  1'b1);
        check_eq("wfirst_m1_awready", m1_awready, 1'b0);
        tick();
        check_eq("wfirst_s_wvalid_a", s_wvalid,  1'b0);
        check_eq("wfirst_m1_wready_a", m1_wready, 1'b0);
        check_eq("wfirst_s_awvalid",  s_awvalid, 1'b1);
        check_eq("wfirst_s_bready_a", s_bready,  1'b0);
        tick();
        check_eq("wfirst_s_wvalid_b", s_wvalid,  1'b0);
        check_eq("wfirst_s_bready_b", s_bready,  1'b0);
        s_awready = 1'b1;
        #1;
        check_eq("wfirst_m1_awready_b", m1_awready, 1'b1);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b10;
        #1;
        check_eq("wfirst_m1_bvalid", m1_bvalid, 1'b1);
        check_eq("wfirst_m1_bresp",  m1_bresp,  2'b10);
        check_eq("wfirst_s_bready",  s_bready,  1'b1);
        tick();
        s_bvalid = 1'b0; s_bresp = 2'b00; m1_bready = 1'b0; m0_bready = 1'b0;
        check_eq("wfirst_end_gnt", gnt, 2'b00);

        // ---- m1 read held off while m0 stalls its write response ----
        m0_awaddr = 4'h4; m0_wdata = 32'hA5A5A5A5; m0_wstrb = 4'hF;
        m0_awvalid = 1'b1; m0_wvalid = 1'b1;
        tick();
        check_eq("hold_gnt0", gnt, 2'b01);
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        m1_araddr = 4'h8; m1_arvalid = 1'b1; s_bvalid = 1'b1; s_arready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("hold_m1_arready", m1_arready, 1'b0);
            check_eq("hold_s_arvalid",  s_arvalid,  1'b0);
            check_eq("hold_m0_bvalid",  m0_bvalid,  1'b1);
            tick();
        end
        m0_bready = 1'b1;
        #1;
        check_eq("hold_s_bready", s_bready, 1'b1);
        tick();
        m0_bready = 1'b0; s_bvalid = 1'b0;
        check_eq("hold_idle_arready", m1_arready, 1'b0);
        tick();
        check_eq("hold_gnt1",     gnt,       2'b10);
        check_eq("hold_s_araddr", s_araddr,  4'h8);
        check_eq("hold_m1_arready_b", m1_arready, 1'b1);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'hCAFEF00D; s_rresp = 2'b00; m1_rready = 1'b1;
        #1;
        check_eq("hold_m1_rdata", m1_rdata, 32'hCAFEF00D);
        check_eq("hold_m1_rresp", m1_rresp, 2'b00);
        tick();
        s_rvalid = 1'b0; m1_rready = 1'b0;

        // ---- m0 holds write and read: write first, read next ----
        m0_awaddr = 4'h8; m0_wdata = 32'h0BADF00D; m0_araddr = 4'hC;
        m0_awvalid = 1'b1; m0_wvalid = 1'b1; m0_arvalid = 1'b1;
        tick();
        check_eq("wr1st_gnt",       gnt,       2'b01);
        check_eq("wr1st_s_awvalid", s_awvalid, 1'b1);
        check_eq("wr1st_s_arvalid", s_arvalid, 1'b0);
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; m0_bready = 1'b1;
        tick();
        s_bvalid = 1'b0; m0_bready = 1'b0;
        check_eq("wr1st_idle_arvalid", s_arvalid, 1'b0);
        tick();
        check_eq("wr1st_rd_gnt",     gnt,       2'b01);
        check_eq("wr1st_rd_arvalid", s_arvalid, 1'b1);
        check_eq("wr1st_rd_araddr",  s_araddr,  4'hC);
        s_arready = 1'b1;
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0; m0_rready = 1'b1;
        #1;
        check_eq("rdata_s_rready", s_rready, 1'b1);

        // ---- asynchronous reset in RDATA ----
        areset = 1'b1;
        #1;
        check_eq("arst_gnt",      gnt,      2'b00);
        check_eq("arst_s_rready", s_rready, 1'b0);
        tick();
        areset = 1'b0; m0_rready = 1'b0;
        m1_araddr = 4'h4; m1_arvalid = 1'b1;
        #1;
        check_eq("arst_idle_gnt", gnt, 2'b00);
        tick();
        check_eq("arst_rd_gnt",    gnt,      2'b10);
        check_eq("arst_rd_araddr", s_araddr, 4'h4);
        s_arready = 1'b1;
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h5555AAAA; s_rresp = 2'b00; m1_rready = 1'b1;
        #1;
        check_eq("arst_m1_rdata",  m1_rdata,  32'h5555AAAA);
        check_eq("arst_m1_rvalid", m1_rvalid, 1'b1);
        tick();
        s_rvalid = 1'b0; m1_rready = 1'b0;
        check_eq("arst_end_gnt", gnt, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
